// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   - FSM state encoding (IDLE/GRANT/TURN)
//   - default select width
//   - onehot(): index to one-hot grant vector, sized for the widest build (16 requesters)
package arb_pkg;

  localparam int unsigned DefaultSelW = 4;
  localparam int unsigned MaxReq      = 16;
  localparam int unsigned MaxSelW     = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t GRANT = 2'd1;
  localparam arb_state_t TURN  = 2'd2;

  function automatic logic [MaxReq-1:0] onehot(input logic [MaxSelW-1:0] index);
    logic [MaxReq-1:0] v;
    v        = '0;
    v[index] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Arbiter <-> bus-master bundle.
//   req       : per-requester level request (masters drive)
//   gnt       : registered one-hot grant
//   sel       : registered mux select (owner index during GRANT)
//   gnt_valid : a grant is active
//   busy      : arbiter in GRANT or TURN
//   timeout   : forced-release pulse (only when ARB_TIMEOUT_EN is defined)
// Modports: master = requester side, slave = arbiter side.
interface rr_bus_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 16,
  parameter int unsigned SEL_W   = DefaultSelW
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               gnt_valid;
  logic               busy;

`ifdef ARB_TIMEOUT_EN
  logic               timeout;

  modport master (output req, input gnt, input sel, input gnt_valid, input busy, input timeout);
  modport slave  (input req, output gnt, output sel, output gnt_valid, output busy,
                  output timeout);
`else
  modport master (output req, input gnt, input sel, input gnt_valid, input busy);
  modport slave  (input req, output gnt, output sel, output gnt_valid, output busy);
`endif

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin winner search.
//   req    : request vector
//   ptr    : highest-priority index (must be < NUM_REQ)
//   winner : first set req bit at or after ptr, wrapping
//   found  : any req bit set
// The request vector is duplicated and bits below ptr in the lower copy are masked off, so a
// plain lowest-set-bit search over the double vector yields the wrapped search order.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 16,
  parameter int unsigned SEL_W   = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] keep;
  logic [2*NUM_REQ-1:0] masked;

  assign dbl    = {req, req};
  assign keep   = {(2*NUM_REQ){1'b1}} << ptr;
  assign masked = dbl & keep;

  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx   = i;
      end
    end
    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
    winner = SEL_W'(idx);
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing the 32-bit 16:1 mux datapath among up to NUM_REQ requesters.
// Grants are held until the owner drops req (no preemption); one TURN cycle separates owners.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : rr_bus_arbiter_if.slave (req in; gnt/sel/gnt_valid/busy[/timeout] out)
// Optional: define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles when another
// requester is waiting; adds the timeout pulse output.
// Constraints: 2 <= NUM_REQ <= 16, 2**SEL_W >= NUM_REQ.
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 16,
  parameter int unsigned SEL_W    = DefaultSelW,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  rr_bus_arbiter_if.slave  bus
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic [SEL_W-1:0]   winner;
  logic               found;
  logic [MaxReq-1:0]  win_onehot;
  logic [SEL_W-1:0]   ptr_after_owner;
  logic               release_vol;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  assign win_onehot      = onehot(MaxSelW'(winner));
  assign ptr_after_owner = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
  assign release_vol     = ~bus.req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;
  logic             others_pending;
  logic             hold_expired;

  assign others_pending = |(bus.req & ~gnt_q);
  // hold_q counts completed GRANT cycles minus one, so this edge ends the MAX_HOLD-th cycle.
  assign hold_expired   = (hold_q >= HoldW'(MAX_HOLD - 1));
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = win_onehot[NUM_REQ-1:0];
          sel_d   = winner;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        if (hold_q != HoldW'(MAX_HOLD)) hold_d = hold_q + 1'b1;
        if (release_vol || (hold_expired && others_pending)) begin
          state_d   = TURN;
          gnt_d     = '0;
          ptr_d     = ptr_after_owner;
          timeout_d = ~release_vol;
        end
`else
        if (release_vol) begin
          state_d = TURN;
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
        end
`endif
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.busy      = (state_q != IDLE);

endmodule
